// File: rtl/ir_packet_gen.sv
// Per-car IR packet transmitter.
// Serialises one remote-control packet (start, car-select, four direction
// bursts, each followed by a gap) as carrier-modulated pulses on IR_OUT.
module ir_packet_gen #(
  parameter int CLK_FREQ       = 50000000,
  parameter int CARRIER_FREQ   = 40000,
  parameter int START_BURST    = 191,
  parameter int CAR_SEL_BURST  = 47,
  parameter int GAP            = 25,
  parameter int ASSERT_BURST   = 47,
  parameter int DEASSERT_BURST = 22
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SEND_PACKET,
  input  logic [3:0] COMMAND,
  output logic       IR_OUT,
  output logic       BUSY,
  output logic       DONE
);

  localparam int HALF = CLK_FREQ / (2 * CARRIER_FREQ);
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int M1   = (START_BURST > CAR_SEL_BURST) ? START_BURST : CAR_SEL_BURST;
  localparam int M2   = (GAP > ASSERT_BURST) ? GAP : ASSERT_BURST;
  localparam int M3   = (M1 > M2) ? M1 : M2;
  localparam int MAXB = (M3 > DEASSERT_BURST) ? M3 : DEASSERT_BURST;
  localparam int BW   = $clog2(MAXB + 1);

  typedef enum logic [3:0] {
    IDLE, START, GAP_S, CARSEL, GAP_C, RIGHT, GAP_R,
    LEFT, GAP_L, BACK, GAP_B, FWD, GAP_F
  } state_t;

  state_t          state, state_n;
  logic [HW-1:0]   half_cnt, half_n;
  logic            phase, phase_n;
  logic [BW-1:0]   burst_cnt, burst_n;
  logic [BW-1:0]   seg_len;
  logic [3:0]      cmd, cmd_n;
  logic            ir_n, done_n, half_wrap;

  function automatic logic is_burst(input state_t s);
    return (s == START) || (s == CARSEL) || (s == RIGHT) ||
           (s == LEFT)  || (s == BACK)   || (s == FWD);
  endfunction

  function automatic state_t next_seg(input state_t s);
    case (s)
      START:   return GAP_S;
      GAP_S:   return CARSEL;
      CARSEL:  return GAP_C;
      GAP_C:   return RIGHT;
      RIGHT:   return GAP_R;
      GAP_R:   return LEFT;
      LEFT:    return GAP_L;
      GAP_L:   return BACK;
      BACK:    return GAP_B;
      GAP_B:   return FWD;
      FWD:     return GAP_F;
      default: return IDLE;
    endcase
  endfunction

  assign BUSY = (state != IDLE);

  // Length of the current segment in carrier periods.
  always_comb begin
    seg_len = BW'(GAP);
    case (state)
      START:   seg_len = BW'(START_BURST);
      CARSEL:  seg_len = BW'(CAR_SEL_BURST);
      RIGHT:   seg_len = cmd[3] ? BW'(ASSERT_BURST) : BW'(DEASSERT_BURST);
      LEFT:    seg_len = cmd[2] ? BW'(ASSERT_BURST) : BW'(DEASSERT_BURST);
      BACK:    seg_len = cmd[1] ? BW'(ASSERT_BURST) : BW'(DEASSERT_BURST);
      FWD:     seg_len = cmd[0] ? BW'(ASSERT_BURST) : BW'(DEASSERT_BURST);
      default: ;
    endcase
  end

  // Next-state logic: carrier counter, period counting, segment sequencing.
  // A carrier period ends when the low half wraps, so carrier phase stays
  // continuous across segment boundaries without any special handling.
  // IR_OUT is computed from the next state/phase so the registered output
  // is aligned with the state it belongs to.
  always_comb begin
    state_n   = state;
    half_n    = half_cnt;
    phase_n   = phase;
    burst_n   = burst_cnt;
    cmd_n     = cmd;
    done_n    = 1'b0;
    half_wrap = (half_cnt == HW'(HALF - 1));
    if (state == IDLE) begin
      // DONE marks the cycle just after completion; requests there are dropped.
      if (SEND_PACKET && !DONE) begin
        state_n = START;
        cmd_n   = COMMAND;
        half_n  = '0;
        phase_n = 1'b1;
        burst_n = '0;
      end
    end else begin
      if (half_wrap) begin
        half_n  = '0;
        phase_n = ~phase;
      end else begin
        half_n = half_cnt + HW'(1);
      end
      if (half_wrap && !phase) begin
        if (burst_cnt == seg_len - BW'(1)) begin
          burst_n = '0;
          state_n = next_seg(state);
          if (state == GAP_F) begin
            done_n  = 1'b1;
            half_n  = '0;
            phase_n = 1'b0;
          end
        end else begin
          burst_n = burst_cnt + BW'(1);
        end
      end
    end
    ir_n = phase_n & is_burst(state_n);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      half_cnt  <= '0;
      phase     <= 1'b0;
      burst_cnt <= '0;
      cmd       <= '0;
      IR_OUT    <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_n;
      half_cnt  <= half_n;
      phase     <= phase_n;
      burst_cnt <= burst_n;
      cmd       <= cmd_n;
      IR_OUT    <= ir_n;
      DONE      <= done_n;
    end
  end

endmodule

// File: doc/ir_packet_gen.md
Name: ir_packet_gen

Overview:
- Per-car IR packet transmitter: serialises one remote-control packet (start burst, car-select burst, four direction bursts) as carrier-modulated pulses on IR_OUT.
- One instance per car colour (yellow, green, blue, red), each with its own carrier and burst parameters.
- IR_OUT of each instance drives the matching car input (yellow_car/green_car/blue_car/red_car) of the downstream colour-select IR multiplexer.
- Upstream control logic issues SEND_PACKET at the packet rate (nominally 10 Hz) together with the current COMMAND.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- CARRIER_FREQ, 40000, carrier frequency in Hz. Half-period HALF = CLK_FREQ/(2*CARRIER_FREQ), integer division, must be >= 1.
- START_BURST, 191, start burst length in carrier periods.
- CAR_SEL_BURST, 47, car-select burst length in carrier periods.
- GAP, 25, inter-burst gap length in carrier periods (output low).
- ASSERT_BURST, 47, direction burst length in carrier periods when the command bit is 1.
- DEASSERT_BURST, 22, direction burst length in carrier periods when the command bit is 0.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- SEND_PACKET  input  1  single-cycle request to transmit one packet.
- COMMAND  input  4  [3]=right, [2]=left, [1]=backward, [0]=forward; sampled on accept.
- IR_OUT  output  1  modulated IR drive to the colour-select mux.
- BUSY  output  1  high while a packet is in progress.
- DONE  output  1  one-cycle pulse when a packet completes.

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE, all counters 0, command latch 0, IR_OUT=0, BUSY=0, DONE=0.
  - Applies immediately, including mid-packet. The aborted packet is dropped and never resumed.
- Accept: in IDLE, SEND_PACKET=1 at edge k latches COMMAND, clears the carrier counter, and enters START.
  - BUSY=1 and IR_OUT=1 from edge k+1 (one-cycle latency).
  - SEND_PACKET while BUSY=1 is ignored; the latched COMMAND is unaffected.
- Carrier:
  - Half-period counter runs 0..HALF-1; the phase bit toggles when the counter wraps.
  - Phase is high for the first half-period of every carrier period.
  - One carrier period = 2*HALF cycles.
  - Carrier phase is continuous across burst/gap boundaries within a packet.
- Burst length counter: counts completed carrier periods in the current segment; it clears on every segment transition.
- IR_OUT = carrier phase AND (current state is a burst state). IR_OUT is registered and is 0 in gap states and IDLE.
- State sequence (each segment lasts exactly its parameter in carrier periods):
  - IDLE -> START(START_BURST) -> GAP_S -> CARSEL(CAR_SEL_BURST) -> GAP_C
  - -> RIGHT -> GAP_R -> LEFT -> GAP_L -> BACK -> GAP_B -> FWD -> GAP_F -> IDLE.
- Direction bursts use ASSERT_BURST if the latched bit is 1, otherwise DEASSERT_BURST.
- Packet length in cycles = 2*HALF*(START_BURST + CAR_SEL_BURST + 6*GAP + sum of the four direction bursts).
- Completion: on the edge that ends GAP_F, the block returns to IDLE with BUSY=0 and DONE=1 for exactly one cycle.
  - A SEND_PACKET in that same cycle is ignored. A SEND_PACKET on the next cycle is accepted.
- Counter widths must hold the largest parameter without overflow; no wrap-around is permitted inside a segment.

Test Plan:
- Bench parameters for all scenarios: CLK_FREQ=100, CARRIER_FREQ=10 (HALF=5), START=4, CAR_SEL=2, GAP=1, ASSERT=3, DEASSERT=1.
- Reset: hold RESET=0 for 3 cycles with SEND_PACKET toggling -> IR_OUT=0, BUSY=0, DONE=0 throughout.
- Single packet: SEND_PACKET pulse with COMMAND=4'b0101 -> BUSY high for exactly 200 cycles, then one DONE pulse.
  - IR_OUT high from the cycle after accept, with a 5-high/5-low pattern for 4 periods.
  - Gaps low for 10 cycles each.
  - Direction bursts of 1, 3, 1, 3 periods.
- All commands 4'b1111: BUSY lasts 240 cycles. COMMAND=4'b0000: BUSY lasts 160 cycles. Pulse counts inside direction bursts match.
- Busy ignore: second SEND_PACKET with COMMAND=4'b1111 at cycle 50 of a 4'b0000 packet -> packet still 160 cycles, all direction bursts 1 period, no extra packet.
- Back-to-back: SEND_PACKET on the DONE cycle is ignored; SEND_PACKET the cycle after DONE starts a new packet with BUSY/IR_OUT high one cycle later.
- Mid-packet reset: assert RESET=0 during LEFT burst while IR_OUT=1 -> IR_OUT and BUSY fall without waiting for a clock edge, no DONE pulse. After release, a new SEND_PACKET produces a full, correct packet.
